// File: rtl/kernel_lsu_pkg.sv
// Shared definitions for the kernel RAM load/store initiator.
// Holds the access-size encoding, the LSU state enum and helpers that turn an
// access size into a byte count or a right-aligned lane mask.
package kernel_lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;  // 2'b11 is reserved and behaves as a word

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_WAIT,
    ST_LOAD_SPLIT,
    ST_STORE_SPLIT,
    ST_FAULT
  } lsu_state_e;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 4'b0001;
      SIZE_HALF: return 4'b0011;
      default:   return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/kernel_lsu_lanes.sv
// Combinational lane logic for the LSU.
// Ports:
//   off_i, size_i, signed_i  - byte offset in word, access size, sign-extend flag
//   wdata_i                  - right-aligned store data
//   lo_word_i, hi_word_i     - RAM words holding the low / high part of a load
//   be_first_o, be_second_o  - byte enables for the first and (split) second access
//   wdata_first_o/second_o   - lane-shifted store data for each access
//   load_o                   - extracted and extended load result
module kernel_lsu_lanes
  import kernel_lsu_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] lo_word_i,
  input  logic [31:0] hi_word_i,
  output logic [3:0]  be_first_o,
  output logic [3:0]  be_second_o,
  output logic [31:0] wdata_first_o,
  output logic [31:0] wdata_second_o,
  output logic [31:0] load_o
);

  logic [4:0]  shamt;
  logic [7:0]  be_span;
  logic [63:0] wshift;
  logic [31:0] raw;

  assign shamt = {off_i, 3'b000};

  // Treating the two accessed words as one 64-bit window lets the same shift
  // serve both single and split accesses: the upper half is the second word.
  assign be_span        = {4'b0000, lane_mask(size_i)} << off_i;
  assign be_first_o     = be_span[3:0];
  assign be_second_o    = be_span[7:4];

  assign wshift         = {32'h0, wdata_i} << shamt;
  assign wdata_first_o  = wshift[31:0];
  assign wdata_second_o = wshift[63:32];

  assign raw = 32'({hi_word_i, lo_word_i} >> shamt);

  always_comb begin
    case (size_i)
      SIZE_BYTE: load_o = signed_i ? {{24{raw[7]}}, raw[7:0]}  : {24'h0, raw[7:0]};
      SIZE_HALF: load_o = signed_i ? {{16{raw[15]}}, raw[15:0]} : {16'h0, raw[15:0]};
      default:   load_o = raw;
    endcase
  end

endmodule

// File: rtl/kernel_lsu.sv
// Load/store initiator driving the kernel RAM data port for the CPU core.
// Ports:
//   clk, reset                      - clock, asynchronous active-high reset
//   req_valid/req_ready             - request handshake (ready only when idle)
//   req_write/addr/size/signed/wdata- byte-addressed request fields
//   resp_valid/resp_rdata/resp_fault- one-cycle response pulse, load data, reject flag
//   mem_addr/wdata/be/write         - RAM data port outputs
//   mem_rdata                       - RAM read data, one cycle after the read issue
// Word-crossing accesses are split into two back-to-back RAM accesses, or
// rejected with a fault when ALLOW_MISALIGNED is 0.
module kernel_lsu
  import kernel_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH       = 13,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_fault,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be,
  output logic                  mem_write,
  input  logic [31:0]           mem_rdata
);

  lsu_state_e            state_q, state_d;
  logic [1:0]            off_q, size_q;
  logic                  signed_q, split_q, store_done_q;
  logic [31:0]           wdata_q, lo_q;
  logic [ADDR_WIDTH-1:0] word_q;

  logic                  in_idle, req_split, reject;
  logic [1:0]            req_off;
  logic [ADDR_WIDTH-1:0] req_word;
  logic [1:0]            l_off, l_size;
  logic                  l_signed;
  logic [31:0]           l_wdata, l_lo;
  logic [3:0]            be_first, be_second;
  logic [31:0]           wdata_first, wdata_second, load_data;

  assign in_idle   = (state_q == ST_IDLE);
  assign req_off   = req_addr[1:0];
  assign req_word  = req_addr[ADDR_WIDTH+1:2];
  assign req_split = ({1'b0, req_off} + size_bytes(req_size)) > 3'd4;
  assign reject    = req_split && (ALLOW_MISALIGNED == 1'b0);

  // The first access is issued from the live request; later cycles work from
  // the held copy, so the lane logic is fed through this mux.
  assign l_off    = in_idle ? req_off    : off_q;
  assign l_size   = in_idle ? req_size   : size_q;
  assign l_signed = in_idle ? req_signed : signed_q;
  assign l_wdata  = in_idle ? req_wdata  : wdata_q;
  assign l_lo     = split_q ? lo_q       : mem_rdata;

  kernel_lsu_lanes u_lanes (
    .off_i          (l_off),
    .size_i         (l_size),
    .signed_i       (l_signed),
    .wdata_i        (l_wdata),
    .lo_word_i      (l_lo),
    .hi_word_i      (mem_rdata),
    .be_first_o     (be_first),
    .be_second_o    (be_second),
    .wdata_first_o  (wdata_first),
    .wdata_second_o (wdata_second),
    .load_o         (load_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      off_q        <= '0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      split_q      <= 1'b0;
      wdata_q      <= '0;
      word_q       <= '0;
      lo_q         <= '0;
      store_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      // Store completion is reported the cycle after the last write.
      store_done_q <= (in_idle && req_valid && req_write && !req_split) ||
                      (state_q == ST_STORE_SPLIT);
      if (in_idle && req_valid) begin
        off_q    <= req_off;
        size_q   <= req_size;
        signed_q <= req_signed;
        split_q  <= req_split;
        wdata_q  <= req_wdata;
        word_q   <= req_word;
      end
      if (state_q == ST_LOAD_SPLIT) lo_q <= mem_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (reject)         state_d = ST_FAULT;
          else if (req_split) state_d = req_write ? ST_STORE_SPLIT : ST_LOAD_SPLIT;
          else                state_d = req_write ? ST_IDLE : ST_LOAD_WAIT;
        end
      end
      ST_LOAD_SPLIT: state_d = ST_LOAD_WAIT;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = store_done_q;
    resp_rdata = '0;
    resp_fault = 1'b0;
    mem_addr   = req_word;
    mem_wdata  = wdata_first;
    mem_be     = 4'b0000;
    mem_write  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !reject) begin
          mem_be    = be_first;
          mem_write = req_write;
        end
      end
      ST_LOAD_SPLIT: begin
        mem_addr = word_q + ADDR_WIDTH'(1);
        mem_be   = be_second;
      end
      ST_STORE_SPLIT: begin
        mem_addr  = word_q + ADDR_WIDTH'(1);
        mem_be    = be_second;
        mem_write = 1'b1;
        mem_wdata = wdata_second;
      end
      ST_LOAD_WAIT: begin
        resp_valid = 1'b1;
        resp_rdata = load_data;
      end
      ST_FAULT: begin
        resp_valid = 1'b1;
        resp_fault = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_kernel_lsu.sv
// Directed bench for kernel_lsu: one instance splits misaligned accesses, a
// second instance rejects them. Both share the request inputs and each has
// its own behavioural RAM (read data one cycle after issue).
module tb_kernel_lsu;

  logic        clk = 1'b0;
  logic        reset, preload;
  logic        req_valid, req_write, req_signed;
  logic [14:0] req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;

  logic        req_ready, resp_valid, resp_fault, mem_write;
  logic [31:0] resp_rdata, mem_wdata, mem_rdata;
  logic [12:0] mem_addr;
  logic [3:0]  mem_be;

  logic        f_req_ready, f_resp_valid, f_resp_fault, f_mem_write;
  logic [31:0] f_resp_rdata, f_mem_wdata, f_mem_rdata;
  logic [12:0] f_mem_addr;
  logic [3:0]  f_mem_be;

  logic [31:0] ram0 [0:8191];
  logic [31:0] ram1 [0:8191];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  kernel_lsu #(.ADDR_WIDTH(13), .ALLOW_MISALIGNED(1'b1)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
    .req_signed(req_signed), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_write(mem_write),
    .mem_rdata(mem_rdata)
  );

  kernel_lsu #(.ADDR_WIDTH(13), .ALLOW_MISALIGNED(1'b0)) u_dut_nomis (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(f_req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
    .req_signed(req_signed), .req_wdata(req_wdata), .resp_valid(f_resp_valid),
    .resp_rdata(f_resp_rdata), .resp_fault(f_resp_fault), .mem_addr(f_mem_addr),
    .mem_wdata(f_mem_wdata), .mem_be(f_mem_be), .mem_write(f_mem_write),
    .mem_rdata(f_mem_rdata)
  );

  always @(posedge clk) begin
    if (preload) begin
      ram0[4] <= 32'hDDCCBBAA; ram0[5] <= 32'h44332211;
      ram0[13'h1FFF] <= 32'h87654321; ram0[0] <= 32'h0FEDCBA9;
    end else if (mem_write) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) ram0[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end else begin
      mem_rdata <= ram0[mem_addr];
    end
  end

  always @(posedge clk) begin
    if (preload) begin
      ram1[4] <= 32'hDDCCBBAA; ram1[5] <= 32'h44332211;
    end else if (f_mem_write) begin
      for (int b = 0; b < 4; b++)
        if (f_mem_be[b]) ram1[f_mem_addr][8*b +: 8] <= f_mem_wdata[8*b +: 8];
    end else begin
      f_mem_rdata <= ram1[f_mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock, drop any request, and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1 req_valid = 1'b0;
    #1;
  endtask

  task automatic drive(input logic w, input logic [14:0] a, input logic [1:0] s,
                       input logic sg, input logic [31:0] d);
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_size   = s;
    req_signed = sg;
    req_wdata  = d;
    #1;
  endtask

  task automatic load_word(input string tag, input logic [14:0] a, input logic [31:0] exp);
    drive(1'b0, a, 2'b10, 1'b0, 32'h0);
    tick();
    chk({tag, "_vld"}, resp_valid, 1);
    chk(tag, resp_rdata, exp);
    tick();
  endtask

  initial begin
    reset = 1'b1; preload = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_size = '0; req_signed = 1'b0; req_wdata = '0;
    tick(); tick();
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_fault", resp_fault, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_f_resp_valid", f_resp_valid, 0);
    preload = 1'b0; reset = 1'b0;
    tick();

    // Signed byte load at 0x13
    drive(1'b0, 15'h0013, 2'b00, 1'b1, 32'h0);
    chk("sb_addr", mem_addr, 4);
    chk("sb_be", mem_be, 4'b1000);
    chk("sb_resp_T", resp_valid, 0);
    tick();
    chk("sb_vld", resp_valid, 1);
    chk("sb_data", resp_rdata, 32'hFFFFFFDD);
    tick();

    // Unsigned and signed half loads at 0x12
    drive(1'b0, 15'h0012, 2'b01, 1'b0, 32'h0);
    chk("uh_be", mem_be, 4'b1100);
    tick();
    chk("uh_data", resp_rdata, 32'h0000DDCC);
    tick();
    drive(1'b0, 15'h0012, 2'b01, 1'b1, 32'h0);
    tick();
    chk("sh_data", resp_rdata, 32'hFFFFDDCC);
    tick();

    // Split word load at 0x13
    drive(1'b0, 15'h0013, 2'b10, 1'b0, 32'h0);
    chk("sw_addr0", mem_addr, 4);
    chk("sw_be0", mem_be, 4'b1000);
    tick();
    chk("sw_addr1", mem_addr, 5);
    chk("sw_be1", mem_be, 4'b0111);
    chk("sw_ready1", req_ready, 0);
    chk("sw_vld1", resp_valid, 0);
    tick();
    chk("sw_vld2", resp_valid, 1);
    chk("sw_data", resp_rdata, 32'h332211DD);
    tick();

    // Split word load wrapping from the top word to word 0
    drive(1'b0, 15'h7FFE, 2'b10, 1'b0, 32'h0);
    chk("wr_addr0", mem_addr, 13'h1FFF);
    chk("wr_be0", mem_be, 4'b1100);
    tick();
    chk("wr_addr1", mem_addr, 0);
    chk("wr_be1", mem_be, 4'b0011);
    tick();
    chk("wr_data", resp_rdata, 32'hCBA98765);
    tick();

    // Misaligned word load rejected by the non-splitting instance
    drive(1'b0, 15'h0011, 2'b10, 1'b0, 32'h0);
    chk("f_be", f_mem_be, 0);
    chk("f_write", f_mem_write, 0);
    tick();
    chk("f_vld", f_resp_valid, 1);
    chk("f_fault", f_resp_fault, 1);
    chk("f_rdata", f_resp_rdata, 0);
    tick(); tick();
    drive(1'b0, 15'h0010, 2'b10, 1'b0, 32'h0);
    tick();
    chk("fa_vld", f_resp_valid, 1);
    chk("fa_fault", f_resp_fault, 0);
    chk("fa_data", f_resp_rdata, 32'hDDCCBBAA);
    tick();

    // Split half store 0xBEEF at 0x13
    drive(1'b1, 15'h0013, 2'b01, 1'b0, 32'h0000BEEF);
    chk("hs_addr0", mem_addr, 4);
    chk("hs_be0", mem_be, 4'b1000);
    chk("hs_wr0", mem_write, 1);
    chk("hs_wd0", mem_wdata[31:24], 8'hEF);
    tick();
    chk("hs_addr1", mem_addr, 5);
    chk("hs_be1", mem_be, 4'b0001);
    chk("hs_wr1", mem_write, 1);
    chk("hs_wd1", mem_wdata[7:0], 8'hBE);
    chk("hs_vld1", resp_valid, 0);
    tick();
    chk("hs_vld2", resp_valid, 1);
    chk("hs_rdata", resp_rdata, 0);
    chk("hs_wr2", mem_write, 0);
    tick();
    load_word("hs_rb4", 15'h0010, 32'hEFCCBBAA);
    load_word("hs_rb5", 15'h0014, 32'h443322BE);

    // Aligned byte store 0x5A at 0x15
    drive(1'b1, 15'h0015, 2'b00, 1'b0, 32'h0000005A);
    chk("bs_addr", mem_addr, 5);
    chk("bs_be", mem_be, 4'b0010);
    chk("bs_wd", mem_wdata[15:8], 8'h5A);
    tick();
    chk("bs_vld", resp_valid, 1);
    chk("bs_wr1", mem_write, 0);
    tick();
    load_word("bs_rb5", 15'h0014, 32'h44335ABE);

    // Reset during a split store, after its first write
    drive(1'b1, 15'h0013, 2'b10, 1'b0, 32'hA1B2C3D4);
    chk("rs_be0", mem_be, 4'b1000);
    chk("rs_wd0", mem_wdata[31:24], 8'hD4);
    tick();
    chk("rs_wr1", mem_write, 1);
    chk("rs_wd1", mem_wdata[23:0], 24'hA1B2C3);
    reset = 1'b1;
    #1;
    chk("rs_vld", resp_valid, 0);
    chk("rs_wr", mem_write, 0);
    chk("rs_be", mem_be, 0);
    chk("rs_ready", req_ready, 1);
    reset = 1'b0;
    tick(); tick();
    load_word("rs_rb4", 15'h0010, 32'hD4CCBBAA);
    load_word("rs_rb5", 15'h0014, 32'h44335ABE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
